// File: rtl/pd_pkg.sv
// rtl/pd_pkg.sv - shared constants and event type for the pattern-detector event logger
//
// Purpose: event-id encodings, default widths/depth and the event record
// layout used by the logger top, its FIFO and its stream interface.
// Ports: none (package).
package pd_pkg;

  localparam int PD_TS_W  = 16;
  localparam int PD_CNT_W = 16;
  localparam int PD_DEPTH = 8;

  localparam logic PD_EVT_P1 = 1'b0;
  localparam logic PD_EVT_P2 = 1'b1;

  // Event record: id in the MSB, timestamp below it.
  localparam int PD_EVT_W = 1 + PD_TS_W;

  typedef struct packed {
    logic                id;
    logic [PD_TS_W-1:0]  ts;
  } pd_evt_t;

  function automatic int pd_evt_width(input int ts_w);
    return 1 + ts_w;
  endfunction

endpackage

// File: rtl/pd_event_logger_if.sv
// rtl/pd_event_logger_if.sv - valid/ready event stream between the logger and its consumer
//
// Purpose: bundles the head-of-queue event handshake.
// Signals: evt_valid (queue non-empty), evt_ready (consumer accepts head),
//          evt_id (0 = pattern1, 1 = pattern2), evt_ts (digit index of the match).
// Modports: master = logger side, slave = consumer side.
interface pd_event_logger_if
  import pd_pkg::*;
#(
  parameter int TS_W = PD_TS_W
);
  logic            evt_valid;
  logic            evt_ready;
  logic            evt_id;
  logic [TS_W-1:0] evt_ts;

  modport master (output evt_valid, output evt_id, output evt_ts, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_ts, output evt_ready);
endinterface

// File: rtl/pd_evt_fifo.sv
// rtl/pd_evt_fifo.sv - synchronous FIFO holding logged pattern events
//
// Purpose: DEPTH x W storage with pointer-MSB full/empty detection; a push
// into a full FIFO is accepted when a pop happens in the same cycle.
// Ports: clk, reset_n (async active-low), flush (sync empty, wins over push/pop),
//        push/push_data, pop, head (entry at read pointer), full, empty, level.
module pd_evt_fifo
  import pd_pkg::*;
#(
  parameter  int DEPTH = PD_DEPTH,
  parameter  int W     = PD_EVT_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  // Same slot, opposite lap: writer is a full DEPTH ahead of the reader.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pd_event_logger.sv
// rtl/pd_event_logger.sv - turns pattern-detector level flags into timestamped, queued events
//
// Purpose: rising-edge detect on pattern1/pattern2, digit counter ts, event
// FIFO with overflow flag, optional saturating per-pattern match counters.
// Optional feature macro: PD_LOG_COUNTERS_EN (defined = counters built,
// undefined = cnt_p1/cnt_p2 tied to 0).
// Ports: clk, reset_n (async active-low), enable (digit strobe), pattern1,
//        pattern2 (detector flags), clear (sync flush), evt (event stream,
//        master side), cnt_p1, cnt_p2, overflow (sticky drop), level (occupancy).
module pd_event_logger
  import pd_pkg::*;
#(
  parameter int DEPTH = PD_DEPTH,
  parameter int TS_W  = PD_TS_W,
  parameter int CNT_W = PD_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      pattern1,
  input  logic                      pattern2,
  input  logic                      clear,
  pd_event_logger_if.master         evt,
  output logic [CNT_W-1:0]          cnt_p1,
  output logic [CNT_W-1:0]          cnt_p2,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int EVT_W = 1 + TS_W;

  logic [TS_W-1:0]  ts;
  logic             prev1;
  logic             prev2;
  logic             rise1;
  logic             rise2;
  logic             push_req;
  logic             pop_req;
  logic             drop;
  logic [EVT_W-1:0] push_data;
  logic [EVT_W-1:0] head;
  logic             full;
  logic             empty;

  assign rise1 = pattern1 & ~prev1;
  assign rise2 = pattern2 & ~prev2;

  // A simultaneous rise of both flags logs pattern2 only.
  assign push_req  = (rise1 | rise2) & ~clear;
  assign push_data = {(rise2 ? PD_EVT_P2 : PD_EVT_P1), ts};
  assign pop_req   = ~empty & evt.evt_ready & ~clear;
  assign drop      = push_req & full & ~pop_req;

  pd_evt_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (clear),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop_req),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Head fields are masked while empty so idle outputs read as zero.
  assign evt.evt_valid = ~empty;
  assign evt.evt_id    = empty ? 1'b0 : head[TS_W];
  assign evt.evt_ts    = empty ? '0 : head[TS_W-1:0];

  // prev1/prev2 follow the flags even during clear so held levels do not re-fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts       <= '0;
      prev1    <= 1'b0;
      prev2    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev1 <= pattern1;
      prev2 <= pattern2;
      if (clear) begin
        ts       <= '0;
        overflow <= 1'b0;
      end else begin
        if (enable) ts       <= ts + TS_W'(1);
        if (drop)   overflow <= 1'b1;
      end
    end
  end

`ifdef PD_LOG_COUNTERS_EN
  // Counters see every rising edge, including ones the FIFO had to drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p1 <= '0;
      cnt_p2 <= '0;
    end else if (clear) begin
      cnt_p1 <= '0;
      cnt_p2 <= '0;
    end else begin
      if (rise1 && (cnt_p1 != {CNT_W{1'b1}})) cnt_p1 <= cnt_p1 + CNT_W'(1);
      if (rise2 && (cnt_p2 != {CNT_W{1'b1}})) cnt_p2 <= cnt_p2 + CNT_W'(1);
    end
  end
`else
  assign cnt_p1 = '0;
  assign cnt_p2 = '0;
`endif

endmodule

// File: tb/tb_pd_event_logger.sv
// tb/tb_pd_event_logger.sv - self-checking bench for pd_event_logger
module tb_pd_event_logger;
  import pd_pkg::*;

  localparam int DEPTH = 8;
  localparam int TS_W  = 16;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef PD_LOG_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             pattern1 = 1'b0;
  logic             pattern2 = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] cnt_p1;
  logic [CNT_W-1:0] cnt_p2;
  logic             overflow;
  logic [LW-1:0]    level;

  pd_event_logger_if #(.TS_W(TS_W)) evt ();

  pd_event_logger #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .pattern1 (pattern1),
    .pattern2 (pattern2),
    .clear    (clear),
    .evt      (evt),
    .cnt_p1   (cnt_p1),
    .cnt_p2   (cnt_p2),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: a queue of pending events plus plain counters.
  typedef struct packed {
    logic            id;
    logic [TS_W-1:0] ts;
  } ev_t;

  ev_t             mq[$];
  ev_t             popped[$];
  logic [TS_W-1:0] m_ts;
  logic            m_prev1;
  logic            m_prev2;
  logic            m_ovf;
  int              m_c1;
  int              m_c2;
  bit              run = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_ts = '0;
    m_prev1 = 1'b0;
    m_prev2 = 1'b0;
    m_ovf = 1'b0;
    m_c1 = 0;
    m_c2 = 0;
  endtask

  task automatic model_step();
    bit r1;
    bit r2;
    int cmax;
    ev_t e;
    cmax = (1 << CNT_W) - 1;
    r1 = pattern1 && !m_prev1;
    r2 = pattern2 && !m_prev2;
    if (clear) begin
      mq.delete();
      m_ts = '0;
      m_c1 = 0;
      m_c2 = 0;
      m_ovf = 1'b0;
    end else begin
      if (mq.size() > 0 && evt.evt_ready) void'(mq.pop_front());
      if (r1 || r2) begin
        e.id = r2;
        e.ts = m_ts;
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1'b1;
      end
      if (r1 && m_c1 < cmax) m_c1++;
      if (r2 && m_c2 < cmax) m_c2++;
      if (enable) m_ts = m_ts + 1'b1;
    end
    m_prev1 = pattern1;
    m_prev2 = pattern2;
  endtask

  // One clock: log what the consumer takes, advance the model, return at negedge.
  task automatic cyc();
    ev_t e;
    if (reset_n && !clear && evt.evt_valid && evt.evt_ready) begin
      e.id = evt.evt_id;
      e.ts = evt.evt_ts;
      popped.push_back(e);
    end
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("evt_valid", evt.evt_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("evt_id", evt.evt_id, mq[0].id);
        chk("evt_ts", evt.evt_ts, mq[0].ts);
      end
      chk("level", level, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("cnt_p1", cnt_p1, CNT_EN ? m_c1 : 0);
      chk("cnt_p2", cnt_p2, CNT_EN ? m_c2 : 0);
    end
  end

  task automatic digits(input int n);
    enable = 1'b1;
    repeat (n) cyc();
    enable = 1'b0;
  endtask

  // Four digit strobes, then the detector flag for one cycle.
  task automatic match(input bit which);
    digits(4);
    if (which) pattern2 = 1'b1;
    else pattern1 = 1'b1;
    cyc();
    pattern1 = 1'b0;
    pattern2 = 1'b0;
    cyc();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    int vcnt;
    evt.evt_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset evt_valid", evt.evt_valid, 0);
    chk("reset level", level, 0);
    chk("reset overflow", overflow, 0);
    chk("reset evt_id", evt.evt_id, 0);
    chk("reset evt_ts", evt.evt_ts, 0);
    chk("reset cnt_p1", cnt_p1, 0);
    reset_n = 1'b1;
    run = 1'b1;

    // Single match 0,5,3,1
    evt.evt_ready = 1'b1;
    popped.delete();
    digits(4);
    pattern1 = 1'b1;
    cyc();
    pattern1 = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (evt.evt_valid) vcnt++;
      cyc();
    end
    chk("single valid cycles", vcnt, 1);
    chk("single count", popped.size(), 1);
    chk("single id", popped[0].id, 0);
    chk("single ts", popped[0].ts, 4);
    chk("single cnt_p1", cnt_p1, CNT_EN ? 1 : 0);

    // Held pattern2 with enable low
    do_clear();
    popped.delete();
    digits(4);
    pattern2 = 1'b1;
    repeat (11) cyc();
    pattern2 = 1'b0;
    cyc();
    chk("held count", popped.size(), 1);
    chk("held id", popped[0].id, 1);
    chk("held ts", popped[0].ts, 4);

    // Nine matches with no consumer, then drain
    do_clear();
    evt.evt_ready = 1'b0;
    repeat (9) match(1'b0);
    chk("bp level", level, 8);
    chk("bp overflow", overflow, 1);
    chk("bp cnt_p1", cnt_p1, CNT_EN ? 9 : 0);
    popped.delete();
    evt.evt_ready = 1'b1;
    repeat (10) cyc();
    evt.evt_ready = 1'b0;
    chk("drain count", popped.size(), 8);
    for (int i = 0; i < 8; i++) chk("drain ts", popped[i].ts, 4 * (i + 1));

    // Full FIFO with a pop on the edge cycle
    do_clear();
    repeat (8) match(1'b0);
    chk("full level", level, 8);
    chk("full overflow", overflow, 0);
    popped.delete();
    digits(4);
    pattern1 = 1'b1;
    evt.evt_ready = 1'b1;
    cyc();
    pattern1 = 1'b0;
    evt.evt_ready = 1'b0;
    chk("fullpop level", level, 8);
    chk("fullpop overflow", overflow, 0);
    match(1'b0);
    chk("fulldrop overflow", overflow, 1);
    evt.evt_ready = 1'b1;
    repeat (10) cyc();
    evt.evt_ready = 1'b0;
    chk("fullpop drained", popped.size(), 9);
    chk("fullpop first ts", popped[0].ts, 4);
    chk("fullpop last ts", popped[8].ts, 36);

    // Clear on an edge cycle with three queued
    do_clear();
    repeat (3) match(1'b0);
    chk("clr pre level", level, 3);
    digits(4);
    pattern1 = 1'b1;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr level", level, 0);
    chk("clr overflow", overflow, 0);
    chk("clr cnt_p1", cnt_p1, 0);
    repeat (3) cyc();
    chk("clr held valid", evt.evt_valid, 0);
    pattern1 = 1'b0;
    cyc();
    popped.delete();
    evt.evt_ready = 1'b1;
    match(1'b0);
    cyc();
    chk("clr restart count", popped.size(), 1);
    chk("clr restart ts", popped[0].ts, 4);

    // Reset mid-stream with pattern1 held
    do_clear();
    evt.evt_ready = 1'b0;
    repeat (2) match(1'b0);
    chk("rst pre level", level, 2);
    pattern1 = 1'b1;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst evt_valid", evt.evt_valid, 0);
    chk("rst level", level, 0);
    chk("rst cnt_p1", cnt_p1, 0);
    cyc();
    reset_n = 1'b1;
    evt.evt_ready = 1'b1;
    popped.delete();
    cyc();
    cyc();
    cyc();
    pattern1 = 1'b0;
    chk("rst event count", popped.size(), 1);
    chk("rst event id", popped[0].id, 0);
    chk("rst event ts", popped[0].ts, 0);

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
